// File: rtl/five_voter.sv
// rtl/five_voter.sv - five-input threshold voter with per-input synchronizers and registered results
module five_voter #(
    parameter int SYNC_STAGES = 2,
    parameter int THRESHOLD   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       A4,
    input  logic       A5,
    output logic       OUT,
    output logic [2:0] COUNT,
    output logic       UNANIMOUS
);

    // Out-of-range parameters stop elaboration rather than silently misbehaving.
    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("five_voter: SYNC_STAGES must be in 0..3");
    end
    if (THRESHOLD < 1 || THRESHOLD > 5) begin : g_bad_threshold
        $error("five_voter: THRESHOLD must be in 1..5");
    end

    // Bit i carries input A(i+1); the inputs are symmetric so order only matters for readability.
    logic [4:0] raw_votes;
    logic [4:0] synced_votes;

    assign raw_votes = {A5, A4, A3, A2, A1};

    if (SYNC_STAGES == 0) begin : g_no_sync
        // Vote logic samples the inputs directly; the result register is the only flop.
        assign synced_votes = raw_votes;
    end else begin : g_sync
        logic [4:0] stage_q [SYNC_STAGES];

        // Independent flop chain per input bit; every stage clears on reset so no residue survives.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    stage_q[k] <= '0;
                end
            end else begin
                stage_q[0] <= raw_votes;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end

        assign synced_votes = stage_q[SYNC_STAGES-1];
    end

    logic [2:0] count_d;
    logic       out_d;
    logic       unanimous_d;
    logic [2:0] count_q;
    logic       out_q;
    logic       unanimous_q;

    // One sum feeds all three results so they always describe the same sample.
    always_comb begin
        count_d     = {2'b00, synced_votes[0]} + {2'b00, synced_votes[1]}
                    + {2'b00, synced_votes[2]} + {2'b00, synced_votes[3]}
                    + {2'b00, synced_votes[4]};
        out_d       = (count_d >= 3'(THRESHOLD));
        unanimous_d = (count_d == 3'd0) || (count_d == 3'd5);
    end

    // Result register; reset state is "all five votes agree at 0".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= 3'd0;
            out_q       <= 1'b0;
            unanimous_q <= 1'b1;
        end else begin
            count_q     <= count_d;
            out_q       <= out_d;
            unanimous_q <= unanimous_d;
        end
    end

    assign COUNT     = count_q;
    assign OUT       = out_q;
    assign UNANIMOUS = unanimous_q;

endmodule

// File: tb/tb_five_voter.sv
// tb/tb_five_voter.sv - randomized and directed checks of five_voter against a sample-history model
module tb_five_voter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] a   = 5'b00000;

    logic       out_a, un_a, out_b, un_b, out_c, un_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // a: default parameters, b: THRESHOLD=1, c: SYNC_STAGES=0
    five_voter #(.SYNC_STAGES(2), .THRESHOLD(3)) dut_a (
        .clk(clk), .rst(rst), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]), .A5(a[4]),
        .OUT(out_a), .COUNT(cnt_a), .UNANIMOUS(un_a));
    five_voter #(.SYNC_STAGES(2), .THRESHOLD(1)) dut_b (
        .clk(clk), .rst(rst), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]), .A5(a[4]),
        .OUT(out_b), .COUNT(cnt_b), .UNANIMOUS(un_b));
    five_voter #(.SYNC_STAGES(0), .THRESHOLD(3)) dut_c (
        .clk(clk), .rst(rst), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]), .A5(a[4]),
        .OUT(out_c), .COUNT(cnt_c), .UNANIMOUS(un_c));

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every input vector seen at a clock edge since reset; the outputs after an
    // edge describe the vector seen SYNC_STAGES edges earlier (all-zero if none yet).
    logic [4:0] hist[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
        end else begin
            hist.push_back(a);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    end

    function automatic int exp_count(int s);
        if (hist.size() > s) return $countones(hist[hist.size() - 1 - s]);
        return 0;
    endfunction

    // Continuous comparison of all three instances against the model.
    always @(negedge clk) begin
        if (!rst) begin
            int c2, c0;
            c2 = exp_count(2);
            c0 = exp_count(0);
            check("a_count", int'(cnt_a), c2);
            check("a_out",   int'(out_a), int'(c2 >= 3));
            check("a_unan",  int'(un_a),  int'(c2 == 0 || c2 == 5));
            check("b_count", int'(cnt_b), c2);
            check("b_out",   int'(out_b), int'(c2 >= 1));
            check("b_unan",  int'(un_b),  int'(c2 == 0 || c2 == 5));
            check("c_count", int'(cnt_c), c0);
            check("c_out",   int'(out_c), int'(c0 >= 3));
            check("c_unan",  int'(un_c),  int'(c0 == 0 || c0 == 5));
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_a_count"}, int'(cnt_a), 0);
        check({tag, "_a_out"},   int'(out_a), 0);
        check({tag, "_a_unan"},  int'(un_a),  1);
        check({tag, "_b_count"}, int'(cnt_b), 0);
        check({tag, "_c_count"}, int'(cnt_c), 0);
        check({tag, "_c_unan"},  int'(un_c),  1);
    endtask

    initial begin
        // Asynchronous reset assertion, visible before any clock edge.
        #2 rst = 1'b1;
        #1 check_reset_state("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle hold with all votes low.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_count", int'(cnt_a), 0);
            check("idle_out",   int'(out_a), 0);
            check("idle_unan",  int'(un_a),  1);
        end

        // Two votes: latency is exactly three edges.
        @(negedge clk);
        a = 5'b00011;
        repeat (2) @(posedge clk);
        #1 check("two_early_count", int'(cnt_a), 0);
        @(posedge clk);
        #1;
        check("two_count", int'(cnt_a), 2);
        check("two_out",   int'(out_a), 0);
        check("two_unan",  int'(un_a),  0);

        // Three votes reach majority.
        @(negedge clk);
        a = 5'b00111;
        repeat (3) @(posedge clk);
        #1;
        check("three_count", int'(cnt_a), 3);
        check("three_out",   int'(out_a), 1);

        // All five.
        @(negedge clk);
        a = 5'b11111;
        repeat (3) @(posedge clk);
        #1;
        check("five_count", int'(cnt_a), 5);
        check("five_out",   int'(out_a), 1);
        check("five_unan",  int'(un_a),  1);

        // Mid-cycle reset clears immediately; no residue after release.
        #2 rst = 1'b1;
        #1 check_reset_state("mid");
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("post_rst_early_count", int'(cnt_a), 0);
        @(posedge clk);
        #1 check("post_rst_count", int'(cnt_a), 5);

        // THRESHOLD=1 with only A5 set.
        @(negedge clk);
        a = 5'b10000;
        repeat (3) @(posedge clk);
        #1;
        check("t1_out",    int'(out_b), 1);
        check("t1_count",  int'(cnt_b), 1);
        check("t3_out",    int'(out_a), 0);

        // SYNC_STAGES=0 responds on the first edge; default instance has not yet.
        @(negedge clk);
        a = 5'b01010;
        @(posedge clk);
        #1;
        check("s0_count",      int'(cnt_c), 2);
        check("s2_old_count",  int'(cnt_a), 1);

        // Exhaustive sweep, each combination held four cycles.
        for (int v = 0; v < 32; v++) begin
            logic [4:0] vv;
            vv = 5'(v);
            @(negedge clk);
            a = vv;
            repeat (4) @(posedge clk);
            #1;
            check("sweep_count", int'(cnt_a), $countones(vv));
            check("sweep_out",   int'(out_a), int'($countones(vv) >= 3));
        end

        // Random votes with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a = 5'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #1 rst = 1'b1;
                #1 check_reset_state("rnd");
                #1 rst = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
